// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: scoreboard-based RAW stall, taken-branch flush,
// fetch-wait hold and a saturating bubble counter.
// Optional build macro HAZARD_FORWARD_EN: with EX/WB forwarding present, only
// issued loads mark their destination pending.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_id_valid,
  input  logic [2:0]  i_id_rx,
  input  logic [2:0]  i_id_ry,
  input  logic        i_id_rd_x,
  input  logic        i_id_rd_y,
  input  logic        i_id_wr,
  input  logic        i_id_is_ld,
  input  logic        i_wb_valid,
  input  logic        i_wb_wr,
  input  logic [2:0]  i_wb_rx,
  input  logic        i_ex_br_taken,
  input  logic        i_imem_ready,
  output logic        o_pc_en,
  output logic        o_if_id_en,
  output logic        o_if_id_flush,
  output logic        o_id_ex_bubble,
  output logic [7:0]  o_pending,
  output logic [1:0]  o_state,
  output logic [15:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    StFill  = 2'd0,
    StRun   = 2'd1,
    StStall = 2'd2,
    StFlush = 2'd3
  } state_e;

  localparam logic [1:0] FlushLoad = 2'(FLUSH_CYCLES - 1);

  state_e      r_state, w_state_d;
  logic [1:0]  r_flush_cnt, w_flush_cnt_d;
  logic [7:0]  r_pending, w_pending_d, w_pending_clr;
  logic [15:0] r_stall_cnt, w_stall_cnt_d;
  logic        w_hazard, w_active, w_issue, w_sets;

  // Retiring writer clears its bit first; the RF writes through, so hazard
  // detection sees the cleared scoreboard in the same cycle.
  always_comb begin
    w_pending_clr = r_pending;
    if (i_wb_valid && i_wb_wr) w_pending_clr[i_wb_rx] = 1'b0;
  end

  assign w_hazard = i_id_valid & ((i_id_rd_x & w_pending_clr[i_id_rx]) |
                                  (i_id_rd_y & w_pending_clr[i_id_ry]));
  assign w_active = (r_state == StRun) || (r_state == StStall);
  assign w_issue  = i_id_valid & w_active & ~w_hazard & ~i_ex_br_taken & i_imem_ready;

`ifdef HAZARD_FORWARD_EN
  // ALU results are forwarded; only load data arrives too late.
  assign w_sets = w_issue & i_id_wr & i_id_is_ld;
`else
  logic w_unused_is_ld;
  assign w_unused_is_ld = i_id_is_ld;
  assign w_sets = w_issue & i_id_wr;
`endif

  // Scoreboard next state: set of a new writer wins over same-cycle clear.
  always_comb begin
    w_pending_d = w_pending_clr;
    if (w_sets) w_pending_d[i_id_rx] = 1'b1;
  end

  // Next-state and control outputs; reset overrides the enables combinationally.
  always_comb begin
    w_state_d      = r_state;
    w_flush_cnt_d  = r_flush_cnt;
    o_pc_en        = 1'b0;
    o_if_id_en     = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b1;
    unique case (r_state)
      StFill: begin
        o_pc_en    = 1'b1;
        o_if_id_en = 1'b1;
        w_state_d  = StRun;
      end
      StRun, StStall, StFlush: begin
        if (i_ex_br_taken) begin
          o_pc_en       = 1'b1;
          o_if_id_en    = 1'b1;
          o_if_id_flush = 1'b1;
          w_flush_cnt_d = FlushLoad;
          w_state_d     = (FLUSH_CYCLES > 1) ? StFlush : StRun;
        end else if (r_state == StFlush) begin
          o_pc_en    = i_imem_ready;
          o_if_id_en = i_imem_ready;
          w_flush_cnt_d = (r_flush_cnt == 2'd0) ? 2'd0 : r_flush_cnt - 2'd1;
          if (r_flush_cnt <= 2'd1) w_state_d = StRun;
        end else if (!i_imem_ready) begin
          w_state_d = r_state;
        end else if (w_hazard) begin
          w_state_d = StStall;
        end else begin
          o_pc_en        = 1'b1;
          o_if_id_en     = 1'b1;
          o_id_ex_bubble = ~i_id_valid;
          w_state_d      = StRun;
        end
      end
    endcase
    if (!i_reset_n) begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
    end
  end

  // Count bubbles inserted while the pipe is running or stalled; saturate.
  always_comb begin
    w_stall_cnt_d = r_stall_cnt;
    if (o_id_ex_bubble && w_active && (r_stall_cnt != 16'hFFFF)) begin
      w_stall_cnt_d = r_stall_cnt + 16'd1;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StFill;
      r_flush_cnt <= 2'd0;
      r_pending   <= 8'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_d;
      r_flush_cnt <= w_flush_cnt_d;
      r_pending   <= w_pending_d;
      r_stall_cnt <= w_stall_cnt_d;
    end
  end

  assign o_pending   = r_pending;
  assign o_state     = r_state;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: number of cycles ID_EX is bubbled after a taken branch (legal 1..3).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 id_valid  input  1  IF_ID holds a real instruction.
REQ-005 id_rx / id_ry  input  3 each  Rx/Ry fields of the IF_ID instruction.
REQ-006 id_rd_x / id_rd_y  input  1 each  instruction reads Rx / Ry.
REQ-007 id_wr  input  1  instruction writes Rx; id_is_ld  input  1  instruction is ld.
REQ-008 wb_valid, wb_wr  input  1 each; wb_rx  input  3  retiring instruction writes wb_rx this cycle.
REQ-009 ex_br_taken  input  1  branch or jump in EX resolved taken this cycle.
REQ-010 imem_ready  input  1  instruction-memory fetch data valid this cycle.
REQ-011 pc_en / if_id_en  output  1 each  PC / IF_ID register load enables.
REQ-012 if_id_flush  output  1  IF_ID loads a NOP (invalid) next edge.
REQ-013 id_ex_bubble  output  1  ID_EX loads all-zero next edge instead of decoded data.
REQ-014 pending  output  8  scoreboard, bit n = register Rn has an in-flight writer.
REQ-015 state  output  2  FSM state encoding FILL=0, RUN=1, STALL=2, FLUSH=3.
REQ-016 stall_cnt  output  16  saturating count of cycles with id_ex_bubble=1 in state RUN or STALL.

Function
REQ-017 Outputs are combinational from state, flush counter, pending and current inputs; state, counter, pending and stall_cnt are registered.
REQ-018 Clear term: wb_valid & wb_wr clears pending[wb_rx]; hazard evaluation uses pending after this same-cycle clear (RF writes through).
REQ-019 Hazard = id_valid & ((id_rd_x & pending'[id_rx]) | (id_rd_y & pending'[id_ry])), pending' = pending with same-cycle clear applied.
REQ-020 Issue = id_valid & state in {RUN, STALL} & no hazard & no ex_br_taken & imem_ready.
REQ-021 On issue with id_wr, pending[id_rx] sets at next edge; set wins over a same-cycle clear of the same register.
REQ-022 FILL: pc_en=1, if_id_en=1, if_id_flush=0, id_ex_bubble=1; next state RUN after one cycle.
REQ-023 RUN/STALL, priority order: ex_br_taken > !imem_ready > hazard > issue.
REQ-024 ex_br_taken: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_bubble=1; load flush counter with FLUSH_CYCLES-1; go to FLUSH (or RUN if FLUSH_CYCLES=1).
REQ-025 !imem_ready: pc_en=0, if_id_en=0, id_ex_bubble=1; state unchanged.
REQ-026 Hazard: pc_en=0, if_id_en=0, id_ex_bubble=1; go to STALL.
REQ-027 Otherwise: pc_en=1, if_id_en=1, id_ex_bubble=!id_valid; go to RUN.
REQ-028 FLUSH: pc_en=imem_ready, if_id_en=imem_ready, id_ex_bubble=1; counter decrements each cycle; exit to RUN when counter=0; a new ex_br_taken restarts per REQ-024.
REQ-029 stall_cnt saturates at 0xFFFF and never wraps.

Reset
REQ-030 While reset=0: state=FILL, pending=0, flush counter=0, stall_cnt=0, pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1.
REQ-031 Reset asserted mid-STALL or mid-FLUSH aborts immediately; the first edge after release is in FILL.

Configuration
REQ-032 Macro HAZARD_FORWARD_EN defined: EX/WB forwarding exists; only issued loads (id_wr & id_is_ld) set pending; ALU writers never stall.
REQ-033 Macro absent: every issued writer (id_wr) sets pending per REQ-021.

Verification
REQ-034 Release reset -> one FILL cycle (id_ex_bubble=1, pc_en=1), then state=RUN.
REQ-035 No forwarding: add R3 issues, next instr reads R3 -> STALL until wb_rx=3 retires; issue occurs in the clear cycle, pending[3]=0 afterwards.
REQ-036 HAZARD_FORWARD_EN: add R3 then reader of R3 -> no stall; ld R3 then reader of R3 -> STALL until WB clear.
REQ-037 ex_br_taken with FLUSH_CYCLES=2 -> if_id_flush=1 one cycle, id_ex_bubble=1 two cycles, then RUN; a second taken branch in FLUSH restarts the count.
REQ-038 Hazard and ex_br_taken same cycle -> flush wins, pc_en=1, state=FLUSH; imem_ready=0 in RUN -> pc_en=0, state held.
REQ-039 Force 65540 stall cycles -> stall_cnt=0xFFFF; reset mid-stall -> all REQ-030 values at once.
